// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: round-robin sequencer for the six equalizer pots on the
// ADC128S. Each channel takes two SPI frames. The first frame addresses the
// channel. The second frame repeats the address and returns that channel's
// conversion, which is then latched into the matching pot register.
module pot_scan_ctrl #(
  parameter int CH_LP   = 1,
  parameter int CH_B1   = 0,
  parameter int CH_B2   = 4,
  parameter int CH_B3   = 2,
  parameter int CH_HP   = 3,
  parameter int CH_VOL  = 7,
  parameter int GAP_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] volume,
  output logic        scan_done
);

  // Gap counter is wide enough to hold GAP_CYC-1 (GAP_CYC >= 1).
  localparam int              GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYC - 1);
  localparam logic [2:0]      LAST_IDX = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND1,
    S_WAIT1,
    S_SEND2,
    S_WAIT2,
    S_NEXT,
    S_GAP
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [2:0]     r_idx;
  logic [2:0]     w_idx_next;
  logic [GW-1:0]  r_gap_cnt;
  logic [GW-1:0]  w_gap_next;
  logic [2:0]     w_ch_next;
  logic           r_wrt;
  logic [15:0]    r_cmd;
  logic           r_scan_done;
  logic [11:0]    r_pot [6];

  // Next-state, index and gap-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_gap_next   = r_gap_cnt;
    case (r_state)
      S_IDLE:  if (en) w_state_next = S_SEND1;
      S_SEND1: w_state_next = S_WAIT1;
      S_WAIT1: if (done) w_state_next = S_SEND2;
      S_SEND2: w_state_next = S_WAIT2;
      S_WAIT2: if (done) w_state_next = S_NEXT;
      S_NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_idx_next   = 3'd0;
          w_gap_next   = GAP_LOAD;
          w_state_next = S_GAP;
        end else begin
          w_idx_next   = r_idx + 3'd1;
          w_state_next = en ? S_SEND1 : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_next = en ? S_SEND1 : S_IDLE;
        end else begin
          w_gap_next = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ADC channel addressed by the index the FSM is about to use.
  always_comb begin
    w_ch_next = 3'(CH_LP);
    case (w_idx_next)
      3'd0:    w_ch_next = 3'(CH_LP);
      3'd1:    w_ch_next = 3'(CH_B1);
      3'd2:    w_ch_next = 3'(CH_B2);
      3'd3:    w_ch_next = 3'(CH_B3);
      3'd4:    w_ch_next = 3'(CH_HP);
      3'd5:    w_ch_next = 3'(CH_VOL);
      default: w_ch_next = 3'(CH_LP);
    endcase
  end

  // State, index and gap counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_gap_cnt <= w_gap_next;
    end
  end

  // Registered strobes; cmd is only reloaded on entry to SEND1 so it is
  // stable across both frames of a channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrt       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_scan_done <= 1'b0;
    end else begin
      r_wrt       <= (w_state_next == S_SEND1) || (w_state_next == S_SEND2);
      r_scan_done <= (w_state_next == S_NEXT) && (r_idx == LAST_IDX);
      if (w_state_next == S_SEND1) begin
        r_cmd <= {2'b00, w_ch_next, 11'h000};
      end
    end
  end

  // One result register per pot, written only by the second frame's done.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pot
      // Capture the conversion for pot gi when its second frame completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pot[gi] <= 12'h000;
        end else if ((r_state == S_WAIT2) && done && (r_idx == 3'(gi))) begin
          r_pot[gi] <= rd_data[11:0];
        end
      end
    end
  endgenerate

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign scan_done = r_scan_done;
  assign LP_pot    = r_pot[0];
  assign B1_pot    = r_pot[1];
  assign B2_pot    = r_pot[2];
  assign B3_pot    = r_pot[3];
  assign HP_pot    = r_pot[4];
  assign volume    = r_pot[5];

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Testbench for pot_scan_ctrl: stub SPI responder, cmd scoreboard queue,
// and table-driven pot value checks.
module tb_pot_scan_ctrl;

  localparam int GAP = 8;
  localparam int LAT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume;
  logic        scan_done;

  always #5 clk = ~clk;

  pot_scan_ctrl #(.GAP_CYC(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data),
    .LP_pot    (LP_pot),
    .B1_pot    (B1_pot),
    .B2_pot    (B2_pot),
    .B3_pot    (B3_pot),
    .HP_pot    (HP_pot),
    .volume    (volume),
    .scan_done (scan_done)
  );

  typedef struct {
    logic [2:0]  ch;     // ADC channel wired to this pot
    logic [15:0] cmd;    // expected command word
    logic [11:0] pot5a;  // expected value with low byte 8'h5A
    string       name;
  } vec_t;
  vec_t tbl [6];

  logic [11:0] pots [6];
  always_comb begin
    pots[0] = LP_pot; pots[1] = B1_pot; pots[2] = B2_pot;
    pots[3] = B3_pot; pots[4] = HP_pot; pots[5] = volume;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Stub SPI responder: done LAT cycles after each wrt, plus stray pulses on request.
  logic [7:0] rd_lo = 8'h5A;
  int         inject_req_n = 0;
  bit         inject_on_send = 1'b0;
  initial begin
    int resp_cnt = 0;
    int served = 0;
    logic [2:0] resp_ch = 3'd0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_n) begin
        resp_cnt = 0;
      end else begin
        if (served != inject_req_n) begin
          done = 1'b1;
          served++;
        end
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            done = 1'b1;
            rd_data = {4'hF, 1'b0, resp_ch, rd_lo};
          end
        end
        if (wrt) begin
          resp_cnt = LAT;
          resp_ch = cmd[13:11];
          if (inject_on_send) done = 1'b1;
        end
      end
    end
  end

  // Monitor: every wrt pops the expected cmd from the scoreboard queue.
  logic [15:0] exp_cmd_q [$];
  int wrt_cnt = 0, scan_cnt = 0, last_wrt_cyc = 0, last_scan_cyc = 0;
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (wrt) begin
        wrt_cnt++;
        last_wrt_cyc = cyc;
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_wrt: got wrt #%0d with cmd %h, expected no wrt", wrt_cnt, cmd);
        end else begin
          e = exp_cmd_q.pop_front();
          check($sformatf("cmd_wrt%0d", wrt_cnt), 32'(cmd), 32'(e));
          $display("wrt #%0d cmd=%h expected=%h", wrt_cnt, cmd, e);
        end
      end
      if (scan_done) begin
        scan_cnt++;
        last_scan_cyc = cyc;
      end
    end
  end

  task automatic push_ch(input int i);
    exp_cmd_q.push_back(tbl[i].cmd);
    exp_cmd_q.push_back(tbl[i].cmd);
  endtask

  task automatic wait_wrt(input int n, input int budget, input string nm);
    int k = 0;
    while (wrt_cnt < n && k < budget) begin @(negedge clk); k++; end
    check(nm, 32'(wrt_cnt >= n), 32'd1);
  endtask

  task automatic wait_scan(input int n, input int budget, input string nm);
    int k = 0;
    while (scan_cnt < n && k < budget) begin @(negedge clk); k++; end
    check(nm, 32'(scan_cnt >= n), 32'd1);
  endtask

  task automatic check_pots(input string tag, input logic [7:0] lo [6]);
    for (int i = 0; i < 6; i++)
      check({tag, "_", tbl[i].name}, 32'(pots[i]), 32'({1'b0, tbl[i].ch, lo[i]}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish by 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] lo [6];
    tbl[0] = '{ch: 3'd1, cmd: 16'h0800, pot5a: 12'h15A, name: "LP"};
    tbl[1] = '{ch: 3'd0, cmd: 16'h0000, pot5a: 12'h05A, name: "B1"};
    tbl[2] = '{ch: 3'd4, cmd: 16'h2000, pot5a: 12'h45A, name: "B2"};
    tbl[3] = '{ch: 3'd2, cmd: 16'h1000, pot5a: 12'h25A, name: "B3"};
    tbl[4] = '{ch: 3'd3, cmd: 16'h1800, pot5a: 12'h35A, name: "HP"};
    tbl[5] = '{ch: 3'd7, cmd: 16'h3800, pot5a: 12'h75A, name: "VOL"};

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) check({"rst_", tbl[i].name}, 32'(pots[i]), 32'h0);
    check("rst_wrt", 32'(wrt), 32'h0);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_scan_done", 32'(scan_done), 32'h0);
    rst_n = 1'b1;

    // Reset in the middle of LP's WAIT2
    push_ch(0);
    en = 1'b1;
    wait_wrt(2, 200, "reach_wait2");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("async_rst_cmd", 32'(cmd), 32'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) check({"rst2_", tbl[i].name}, 32'(pots[i]), 32'h0);
    check("rst2_wrt", 32'(wrt), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_rst", 32'(wrt_cnt), 32'd2);

    // First full scan
    base = wrt_cnt;
    for (int i = 0; i < 6; i++) push_ch(i);
    en = 1'b1;
    wait_scan(1, 2000, "scan1_done");
    check("wrts_per_scan", 32'(wrt_cnt - base), 32'd12);
    for (int i = 0; i < 6; i++) check({"scan1_", tbl[i].name}, 32'(pots[i]), 32'(tbl[i].pot5a));

    // Gap length, then drop en during B2 WAIT1
    rd_lo = 8'hA5;
    push_ch(0); push_ch(1); push_ch(2);
    wait_wrt(base + 13, 100, "gap_wrt");
    check("gap_cycles", 32'(last_wrt_cyc - last_scan_cyc), 32'(GAP + 1));
    wait_wrt(base + 17, 500, "b2_send1");
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (300) @(negedge clk);
    check("park_wrts", 32'(wrt_cnt), 32'(base + 18));
    lo = '{8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A};
    check_pots("park", lo);

    // Stray done pulses while parked in IDLE
    repeat (3) begin inject_req_n++; repeat (3) @(negedge clk); end
    check_pots("idle_stray", lo);
    check("idle_stray_wrts", 32'(wrt_cnt), 32'(base + 18));

    // Resume at B3 and finish the scan; then stray done during GAP
    push_ch(3); push_ch(4); push_ch(5);
    en = 1'b1;
    wait_scan(2, 1500, "scan2_done");
    en = 1'b0;
    inject_req_n++;
    repeat (2) @(negedge clk);
    inject_req_n++;
    repeat (50) @(negedge clk);
    lo = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    check_pots("gap_stray", lo);
    check("gap_stray_wrts", 32'(wrt_cnt), 32'(base + 24));

    // Full scan with a stray done during every SEND cycle
    rd_lo = 8'h3C;
    inject_on_send = 1'b1;
    for (int i = 0; i < 6; i++) push_ch(i);
    en = 1'b1;
    wait_scan(3, 2000, "scan3_done");
    en = 1'b0;
    repeat (20) @(negedge clk);
    lo = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    check_pots("send_stray", lo);
    check("send_stray_wrts", 32'(wrt_cnt), 32'(base + 36));
    check("queue_drained", 32'(exp_cmd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
